// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline.
// Produces stall/flush strobes and EX-stage forwarding selects, refills the
// pipe after reset, freezes it on slow data-memory accesses and latches a
// fault on memory timeout.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWEnE,
  input  logic             WBSelE,
  input  logic             PCSelE,
  input  logic [4:0]       RdM,
  input  logic             RegWEnM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWEnW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_MEM_WAIT,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic       lw_hazard;
  logic       mem_stall;
  logic [1:0] fwd_a, fwd_b;

  // State register with synchronous reset into INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Forwarding selects and load-use detection; x0 never participates.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWEnM && RdM != 5'd0 && RdM == Rs1E)      fwd_a = 2'b10;
    else if (RegWEnW && RdW != 5'd0 && RdW == Rs1E) fwd_a = 2'b01;
    if (RegWEnM && RdM != 5'd0 && RdM == Rs2E)      fwd_b = 2'b10;
    else if (RegWEnW && RdW != 5'd0 && RdW == Rs2E) fwd_b = 2'b01;
    lw_hazard = WBSelE && RegWEnE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    mem_stall = MemReqM && !MemReadyM;
  end

  // Next-state logic and strobe generation; reset forces the INIT strobes.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    fault      = 1'b0;
    ForwardAE  = fwd_a;
    ForwardBE  = fwd_b;
    case (state_q)
      S_INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (init_cnt_q == 4'(INIT_CYCLES - 1)) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        if (mem_stall) begin
          {StallF, StallD, StallE, StallM} = '1;
          FlushW     = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = 16'd1;
        end else if (PCSelE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_hazard) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        {StallF, StallD, StallE, StallM} = '1;
        // Stalls stay up on the ready cycle so MEM/WB captures the access.
        if (MemReadyM) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          FlushW = 1'b1;
          if (wait_cnt_q == 16'(MEM_TIMEOUT)) state_d = S_FAULT;
          else wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        {StallF, StallD, StallE, StallM} = '1;
        FlushW = 1'b1;
        fault  = 1'b1;
      end
    endcase
    if (reset) begin
      {StallF, FlushD, FlushE, FlushW} = '1;
      {StallD, StallE, StallM, fault}  = '0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Performance counters, counting only while the pipe is live.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (state_q == S_RUN || state_q == S_MEM_WAIT))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (FlushE && state_q == S_RUN)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
